// File: rtl/reg_file_sb_pkg.sv
// Shared helpers for the reg_file_sb register file: address-width
// calculation and the byte-enable merge used by both write and bypass paths.
package reg_file_sb_pkg;

  localparam int MAX_WIDTH = 1024;
  localparam int MAX_BYTES = MAX_WIDTH / 8;

  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  // Operates on the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0] be
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue,
// cleared by writeback, with set winning when both hit the same register.
module reg_file_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = addr_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SetBusy,
  input  logic [AW-1:0]     SAddr,
  input  logic              WE,
  input  logic [AW-1:0]     WAddr,
  input  logic [NRD*AW-1:0] RAddr,
  output logic [NRD-1:0]    Busy,
  output logic              AnyBusy
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    assign set_hit = SetBusy && (SAddr == AW'(gi)) && !(ZERO_R0 != 0 && gi == 0);
    assign clr_hit = WE && (WAddr == AW'(gi));
    assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
  end

  always_ff @(posedge CLK) begin
    if (RST) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  // Registered state only: a same-cycle set or clear shows up next cycle.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    assign Busy[gi] = busy_reg[RAddr[gi*AW +: AW]];
  end

  assign AnyBusy = |busy_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte-enable write, optional same-cycle
// write forwarding, optional hardwired-zero r0 and a busy scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = addr_width(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WE,
  input  logic [AW-1:0]        WAddr,
  input  logic [WIDTH-1:0]     Data,
  input  logic [NB-1:0]        BE,
  input  logic [NRD*AW-1:0]    RAddr,
  output logic [NRD*WIDTH-1:0] Dout,
  input  logic                 SetBusy,
  input  logic [AW-1:0]        SAddr,
  output logic [NRD-1:0]       Busy,
  output logic                 AnyBusy
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] wr_merged;
  logic             wr_ok;

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    be
  );
    return WIDTH'(byte_merge(MAX_WIDTH'(old_word), MAX_WIDTH'(new_word), MAX_BYTES'(be)));
  endfunction

  assign wr_ok     = WE && !(ZERO_R0 != 0 && WAddr == '0);
  assign wr_merged = merge_w(mem_reg[WAddr], Data, BE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_ok) begin
      mem_reg[WAddr] <= wr_merged;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] fwd;
    assign ra     = RAddr[gi*AW +: AW];
    assign stored = mem_reg[ra];
    assign fwd    = (BYPASS != 0 && WE && WAddr == ra) ? merge_w(stored, Data, BE) : stored;
    // r0 masking sits after the forward mux so a write to r0 never leaks out.
    assign Dout[gi*WIDTH +: WIDTH] = (ZERO_R0 != 0 && ra == '0) ? '0 : fwd;
  end

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .ZERO_R0(ZERO_R0)
  ) u_scoreboard (
    .CLK    (CLK),
    .RST    (RST),
    .SetBusy(SetBusy),
    .SAddr  (SAddr),
    .WE     (WE),
    .WAddr  (WAddr),
    .RAddr  (RAddr),
    .Busy   (Busy),
    .AnyBusy(AnyBusy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed plan steps then random
// traffic, compared against a behavioural register-file model.
module tb_reg_file_sb;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int N  = 2;
  localparam int AW = 5;
  localparam int NB = W / 8;

  logic           CLK = 1'b0;
  logic           RST, WE, SetBusy;
  logic [AW-1:0]  WAddr, SAddr;
  logic [W-1:0]   Data;
  logic [NB-1:0]  BE;
  logic [N*AW-1:0] RAddr;
  logic [N*W-1:0] Dout, Dout_nb;
  logic [N-1:0]   Busy, Busy_nb;
  logic           AnyBusy, AnyBusy_nb;

  int checks   = 0;
  int failures = 0;

  // Model state: "m_" mirrors the default instance, "n_" the no-bypass/no-r0 one.
  logic [W-1:0] m_reg  [D];
  logic [W-1:0] n_reg  [D];
  bit           m_busy [D];
  bit           n_busy [D];

  always #5 CLK = ~CLK;

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(1), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WAddr(WAddr), .Data(Data), .BE(BE),
    .RAddr(RAddr), .Dout(Dout), .SetBusy(SetBusy), .SAddr(SAddr),
    .Busy(Busy), .AnyBusy(AnyBusy)
  );

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_R0(0), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .WE(WE), .WAddr(WAddr), .Data(Data), .BE(BE),
    .RAddr(RAddr), .Dout(Dout_nb), .SetBusy(SetBusy), .SAddr(SAddr),
    .Busy(Busy_nb), .AnyBusy(AnyBusy_nb)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [NB-1:0] be);
    logic [W-1:0] mask;
    for (int i = 0; i < W; i++) mask[i] = be[i/8];
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input int wa, input logic [W-1:0] d,
                       input logic [NB-1:0] be, input int ra0, input int ra1,
                       input logic sb, input int sa);
    RST = rst; WE = we; WAddr = AW'(wa); Data = d; BE = be;
    RAddr = {AW'(ra1), AW'(ra0)}; SetBusy = sb; SAddr = AW'(sa);
  endtask

  task automatic check_model(input string tag);
    int           a;
    logic [W-1:0] e;
    logic [N-1:0] eb, ebn;
    logic         any_m, any_n;
    for (int k = 0; k < N; k++) begin
      a = int'(RAddr[k*AW +: AW]);
      if (a == 0) e = '0;
      else if (WE && int'(WAddr) == a) e = merge(m_reg[a], Data, BE);
      else e = m_reg[a];
      chk($sformatf("%s/dout%0d", tag, k), Dout[k*W +: W], e);
      chk($sformatf("%s/nb_dout%0d", tag, k), Dout_nb[k*W +: W], n_reg[a]);
      eb[k]  = m_busy[a];
      ebn[k] = n_busy[a];
    end
    any_m = 1'b0;
    any_n = 1'b0;
    for (int r = 0; r < D; r++) begin
      any_m |= m_busy[r];
      any_n |= n_busy[r];
    end
    chk({tag, "/busy"}, W'(Busy), W'(eb));
    chk({tag, "/nb_busy"}, W'(Busy_nb), W'(ebn));
    chk({tag, "/any"}, W'(AnyBusy), W'(any_m));
    chk({tag, "/nb_any"}, W'(AnyBusy_nb), W'(any_n));
  endtask

  task automatic update_model();
    if (RST) begin
      for (int r = 0; r < D; r++) begin
        m_reg[r] = '0; n_reg[r] = '0; m_busy[r] = 0; n_busy[r] = 0;
      end
    end else begin
      if (WE && WAddr != '0) m_reg[WAddr] = merge(m_reg[WAddr], Data, BE);
      if (WE) n_reg[WAddr] = merge(n_reg[WAddr], Data, BE);
      if (WE) begin
        m_busy[WAddr] = 0;
        n_busy[WAddr] = 0;
      end
      // Applied after the clear so that a simultaneous set wins.
      if (SetBusy && SAddr != '0) m_busy[SAddr] = 1;
      if (SetBusy) n_busy[SAddr] = 1;
    end
  endtask

  task automatic tick(input string tag);
    @(negedge CLK);
    check_model(tag);
    @(posedge CLK);
    update_model();
    #1;
  endtask

  initial begin
    for (int r = 0; r < D; r++) begin
      m_reg[r] = '0; n_reg[r] = '0; m_busy[r] = 0; n_busy[r] = 0;
    end
    drive(1, 0, 0, '0, '0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    tick("reset");

    // Read every address on both ports after reset.
    for (int a = 0; a < D; a++) begin
      drive(0, 0, 0, '0, '0, a, D - 1 - a, 0, 0);
      #1;
      chk($sformatf("rst_rd%0d", a), Dout[W-1:0], '0);
      tick("rst_scan");
    end

    // Full write, then partial byte-enable write.
    drive(0, 1, 5, 32'hDEADBEEF, 4'hF, 1, 2, 0, 0);
    tick("wr_full");
    drive(0, 0, 0, '0, '0, 5, 5, 0, 0);
    #1;
    chk("rd_full", Dout[W-1:0], 32'hDEADBEEF);
    tick("rd_full_m");
    drive(0, 1, 5, 32'h11223344, 4'b0101, 0, 0, 0, 0);
    tick("wr_be");
    drive(0, 0, 0, '0, '0, 5, 0, 0, 0);
    #1;
    chk("rd_be", Dout[W-1:0], 32'hDE22BE44);
    tick("rd_be_m");

    // Bypass versus stored value.
    drive(0, 1, 7, 32'h01020304, 4'hF, 0, 0, 0, 0);
    tick("wr_r7");
    drive(0, 1, 7, 32'hCAFEF00D, 4'hF, 5, 7, 0, 0);
    #1;
    chk("byp_on", Dout[2*W-1:W], 32'hCAFEF00D);
    chk("byp_off", Dout_nb[2*W-1:W], 32'h01020304);
    tick("bypass");
    drive(0, 0, 0, '0, '0, 5, 7, 0, 0);
    #1;
    chk("byp_on_next", Dout[2*W-1:W], 32'hCAFEF00D);
    chk("byp_off_next", Dout_nb[2*W-1:W], 32'hCAFEF00D);
    tick("bypass_next");

    // Zero register: write and busy to r0 are dropped.
    drive(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 0);
    #1;
    chk("r0_wr_cycle", Dout[W-1:0], '0);
    chk("r0_wr_cycle_p1", Dout[2*W-1:W], '0);
    tick("r0_wr");
    drive(0, 0, 0, '0, '0, 0, 0, 0, 0);
    #1;
    chk("r0_rd", Dout[W-1:0], '0);
    chk("r0_busy", W'(Busy), '0);
    chk("r0_any", W'(AnyBusy), '0);
    tick("r0_rd_m");

    // Scoreboard sequence on r9.
    drive(0, 0, 0, '0, '0, 9, 9, 1, 9);
    tick("sb_set");
    drive(0, 0, 0, '0, '0, 9, 1, 0, 0);
    #1;
    chk("sb_busy9", W'(Busy[0]), 1);
    chk("sb_any", W'(AnyBusy), 1);
    tick("sb_set_m");
    drive(0, 1, 9, 32'h55AA55AA, 4'hF, 9, 9, 1, 9);
    tick("sb_setclr");
    drive(0, 0, 0, '0, '0, 9, 9, 0, 0);
    #1;
    chk("sb_set_wins", W'(Busy[0]), 1);
    tick("sb_set_wins_m");
    drive(0, 1, 9, 32'h0BADF00D, 4'hF, 1, 2, 0, 0);
    tick("sb_clr");
    drive(0, 0, 0, '0, '0, 9, 9, 0, 0);
    #1;
    chk("sb_cleared", W'(Busy), '0);
    chk("sb_any_clr", W'(AnyBusy), '0);
    tick("sb_clr_m");

    // Reset beats a same-cycle write and set.
    drive(0, 1, 3, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0);
    tick("pre_rst_wr");
    drive(1, 1, 3, 32'h12345678, 4'hF, 3, 3, 1, 3);
    tick("rst_mid");
    drive(0, 0, 0, '0, '0, 3, 3, 0, 0);
    #1;
    chk("rst_mid_r3", Dout[W-1:0], '0);
    chk("rst_mid_busy", W'(Busy), '0);
    tick("rst_mid_m");

    // Randomised traffic, biased so addresses collide often.
    for (int i = 0; i < 400; i++) begin
      int wa, ra0, ra1, sa;
      wa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, D - 1));
      ra0 = ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, D - 1));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : int'($urandom_range(0, D - 1));
      sa  = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, D - 1));
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wa, W'($urandom),
            NB'($urandom), ra0, ra1, ($urandom_range(0, 2) == 0), sa);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
